// File: rtl/program_load_ctrl_pkg.sv
// Shared definitions for the program loader: FSM encoding, command bytes and
// the default end-of-program marker.
package program_load_ctrl_pkg;

    localparam int          LEN_DEF           = 32;
    localparam int          RAM_DEPTH_DEF     = 32;
    localparam logic [31:0] HALT_WORD_DEF     = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_CMD      = 3'd0,
        ST_LOAD     = 3'd1,
        ST_LOAD_END = 3'd2,
        ST_RUN      = 3'd3,
        ST_STEP     = 3'd4
    } state_e;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_ESC  = 8'h1B;

    // True when a received byte is present and equals the given command code.
    function automatic logic rx_is(input logic rx_done, input logic [7:0] rx_data,
                                   input logic [7:0] code);
        return rx_done && (rx_data == code);
    endfunction

endpackage

// File: rtl/program_load_ctrl_if.sv
// Byte-stream input and program-memory preload bus of the loader.
// master = UART/fetch-stage side, slave = program_load_ctrl.
interface program_load_ctrl_if
    import program_load_ctrl_pkg::*;
#(
    parameter int LEN = LEN_DEF
);
    logic [7:0]     i_rx_data;
    logic           i_rx_done;
    logic           o_preload_flag;
    logic [LEN-1:0] o_preload_address;
    logic [LEN-1:0] o_preload_instruction;

    modport master (
        output i_rx_data,
        output i_rx_done,
        input  o_preload_flag,
        input  o_preload_address,
        input  o_preload_instruction
    );

    modport slave (
        input  i_rx_data,
        input  i_rx_done,
        output o_preload_flag,
        output o_preload_address,
        output o_preload_instruction
    );
endinterface

// File: rtl/program_load_ctrl_word_assembler.sv
// Packs bytes MSB-first into LEN-bit words; o_word_valid flags the byte that
// completes a word, with o_word carrying the finished word in that same cycle.
module program_load_ctrl_word_assembler
    import program_load_ctrl_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clr,
    input  logic           i_en,
    input  logic [7:0]     i_rx_data,
    input  logic           i_rx_done,
    output logic           o_word_valid,
    output logic [LEN-1:0] o_word
);
    localparam int BYTES = LEN / 8;
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [LEN-9:0] r_partial;
    logic [CW-1:0]  r_cnt;
    logic           w_take;
    logic           w_last;
    logic [LEN-1:0] w_next;

    assign w_take       = i_en && i_rx_done;
    assign w_last       = (r_cnt == CW'(BYTES - 1));
    assign w_next       = {r_partial, i_rx_data};
    assign o_word_valid = w_take && w_last;
    assign o_word       = w_next;

    // Byte shift register and byte-in-word counter; cleared outside LOAD.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_partial <= '0;
            r_cnt     <= '0;
        end else if (w_take) begin
            r_partial <= w_next[LEN-9:0];
            r_cnt     <= w_last ? '0 : (r_cnt + CW'(1));
        end
    end

endmodule

// File: rtl/program_load_ctrl.sv
// Debug sequencer: loads a program from a UART byte stream into fetch-stage
// memory, pulses the pipeline reset, then gates the pipeline (run / single-step).
module program_load_ctrl
    import program_load_ctrl_pkg::*;
#(
    parameter int             LEN               = LEN_DEF,
    parameter int             RAM_DEPTH_PROGRAM = RAM_DEPTH_DEF,
    parameter logic [LEN-1:0] HALT_WORD         = HALT_WORD_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    program_load_ctrl_if.slave   bus,
    input  logic                 i_halt,
    output logic                 o_pipe_rst,
    output logic                 o_stall_flag,
    output logic                 o_load_error,
    output logic [2:0]           o_state
);
    localparam int AW = (RAM_DEPTH_PROGRAM > 1) ? $clog2(RAM_DEPTH_PROGRAM) : 1;

    state_e         r_state;
    state_e         w_state_next;
    logic           w_stall_next;
    logic [AW-1:0]  r_addr;
    logic           r_preload_flag;
    logic [LEN-1:0] r_preload_address;
    logic [LEN-1:0] r_preload_instruction;
    logic           r_pipe_rst;
    logic           r_stall_flag;
    logic           r_load_error;

    logic           w_word_valid;
    logic [LEN-1:0] w_word;
    logic           w_in_load;
    logic           w_addr_last;
    logic           w_is_halt;
    logic           w_last_word;
    logic           w_load_cmd;

    assign w_in_load   = (r_state == ST_LOAD);
    assign w_addr_last = (r_addr == AW'(RAM_DEPTH_PROGRAM - 1));
    assign w_is_halt   = (w_word == HALT_WORD);
    assign w_last_word = w_word_valid && (w_is_halt || w_addr_last);
    assign w_load_cmd  = (r_state == ST_CMD) && rx_is(bus.i_rx_done, bus.i_rx_data, CMD_LOAD);

    program_load_ctrl_word_assembler #(.LEN(LEN)) u_word_assembler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clr        (!w_in_load),
        .i_en         (w_in_load),
        .i_rx_data    (bus.i_rx_data),
        .i_rx_done    (bus.i_rx_done),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Next-state and next-stall decode; halt is checked before any step byte.
    always_comb begin
        w_state_next = r_state;
        w_stall_next = 1'b1;
        case (r_state)
            ST_CMD: begin
                if (bus.i_rx_done) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: w_state_next = ST_LOAD;
                        CMD_RUN:  w_state_next = ST_RUN;
                        CMD_STEP: w_state_next = ST_STEP;
                        default:  w_state_next = ST_CMD;
                    endcase
                end else begin
                    w_state_next = ST_CMD;
                end
            end
            ST_LOAD: begin
                if (w_last_word) begin
                    w_state_next = ST_LOAD_END;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD_END: w_state_next = ST_CMD;
            ST_RUN: begin
                if (i_halt) begin
                    w_state_next = ST_CMD;
                end else begin
                    w_stall_next = 1'b0;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    w_state_next = ST_CMD;
                end else if (bus.i_rx_done) begin
                    case (bus.i_rx_data)
                        CMD_NEXT: w_stall_next = 1'b0;
                        CMD_RUN:  w_state_next = ST_RUN;
                        CMD_ESC:  w_state_next = ST_CMD;
                        default:  w_state_next = ST_STEP;
                    endcase
                end else begin
                    w_state_next = ST_STEP;
                end
            end
            default: w_state_next = ST_CMD;
        endcase
    end

    // State, address counter and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state               <= ST_CMD;
            r_addr                <= '0;
            r_preload_flag        <= 1'b0;
            r_preload_address     <= '0;
            r_preload_instruction <= '0;
            r_pipe_rst            <= 1'b0;
            r_stall_flag          <= 1'b1;
            r_load_error          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_stall_flag   <= w_stall_next;
            r_preload_flag <= w_word_valid;
            // Write cycle is spent in LOAD_END, so the reset pulse never overlaps it.
            r_pipe_rst     <= (r_state == ST_LOAD_END);
            if (w_word_valid) begin
                r_preload_address     <= LEN'(r_addr);
                r_preload_instruction <= w_word;
                r_addr                <= r_addr + AW'(1);
                if (w_addr_last && !w_is_halt) begin
                    r_load_error <= 1'b1;
                end
            end else if (w_load_cmd) begin
                r_addr       <= '0;
                r_load_error <= 1'b0;
            end
        end
    end

    assign bus.o_preload_flag        = r_preload_flag;
    assign bus.o_preload_address     = r_preload_address;
    assign bus.o_preload_instruction = r_preload_instruction;
    assign o_pipe_rst                = r_pipe_rst;
    assign o_stall_flag              = r_stall_flag;
    assign o_load_error              = r_load_error;
    assign o_state                   = r_state;

endmodule
